// File: rtl/sr_ff_driver.sv
// sr_ff_driver
//   Drives an SR flip-flop to a stream of target bits using the minimal S/R
//   excitation, never issuing S=R=1. Optionally reads q back one cycle after
//   the excitation to confirm the flip-flop reached the target.
//
// Configuration macro: SR_FF_DRV_CHECK_EN
//   defined   : IDLE -> DRIVE -> CHECK -> IDLE, mismatch flag/counter active
//   undefined : IDLE -> DRIVE -> IDLE, err/err_cnt tied to 0
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high reset
//   tgt_valid  in   target bit presented
//   tgt_bit    in   requested flip-flop state
//   tgt_ready  out  target can be accepted (IDLE and not in reset)
//   s, r       out  registered set/reset excitation to the flip-flop
//   q_fb       in   q read back from the flip-flop
//   busy       out  target in flight
//   done_cnt   out  completed targets, wraps
//   err        out  sticky mismatch flag
//   err_cnt    out  mismatch count, saturates at all-ones

module sr_ff_driver #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tgt_valid,
  input  logic             tgt_bit,
  output logic             tgt_ready,
  output logic             s,
  output logic             r,
  input  logic             q_fb,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_accept;
  logic             r_s;
  logic             r_r;
  logic [CNT_W-1:0] r_done_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      IDLE: begin
        if (tgt_valid) begin
          w_accept = 1'b1;
          w_next   = DRIVE;
        end
      end
`ifdef SR_FF_DRV_CHECK_EN
      DRIVE:   w_next = CHECK;
      CHECK:   w_next = IDLE;
`else
      DRIVE:   w_next = IDLE;
`endif
      default: w_next = IDLE;
    endcase
  end

  // Excitation is only ever non-zero for the single DRIVE cycle; at most one
  // of the two terms can be 1, so S=R=1 cannot occur.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s <= 1'b0;
      r_r <= 1'b0;
    end else begin
      r_s <= 1'b0;
      r_r <= 1'b0;
      if (w_accept) begin
        r_s <= tgt_bit & ~q_fb;
        r_r <= ~tgt_bit & q_fb;
      end
    end
  end

`ifdef SR_FF_DRV_CHECK_EN
  logic             r_tgt;
  logic             r_err;
  logic [CNT_W-1:0] r_err_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tgt      <= 1'b0;
      r_err      <= 1'b0;
      r_err_cnt  <= '0;
      r_done_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_tgt <= tgt_bit;
      end
      if (r_state == CHECK) begin
        r_done_cnt <= r_done_cnt + CNT_W'(1);
        if (q_fb != r_tgt) begin
          r_err <= 1'b1;
          if (r_err_cnt != '1) begin
            r_err_cnt <= r_err_cnt + CNT_W'(1);
          end
        end
      end
    end
  end

  assign err     = r_err;
  assign err_cnt = r_err_cnt;
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      r_done_cnt <= '0;
    end else if (r_state == DRIVE) begin
      r_done_cnt <= r_done_cnt + CNT_W'(1);
    end
  end

  assign err     = 1'b0;
  assign err_cnt = '0;
`endif

  assign tgt_ready = (r_state == IDLE) && !reset;
  assign busy      = (r_state != IDLE);
  assign s         = r_s;
  assign r         = r_r;
  assign done_cnt  = r_done_cnt;

endmodule
